// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the per-thread PC sequencer.
// The optional PC loader port group is enabled by PC_SEQUENCER_LOADER_EN.
package pc_sequencer_pkg;

  localparam int unsigned PC_WIDTH_DEFAULT     = 10;
  localparam int unsigned THREAD_WIDTH_DEFAULT = 3;

  // Source of a thread's next PC
  typedef enum logic [1:0] {
    NEXT_INC  = 2'd0,
    NEXT_JUMP = 2'd1,
    NEXT_HOLD = 2'd2
  } next_sel_e;

  // Feedback record at the default configuration widths
  typedef struct packed {
    logic                            valid;
    logic [THREAD_WIDTH_DEFAULT-1:0] thread;
    logic [PC_WIDTH_DEFAULT-1:0]     pc;
  } fb_rec_t;

  // Round-robin thread successor
  function automatic int unsigned thread_inc(input int unsigned cur, input int unsigned count);
    return (cur + 1 >= count) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/pc_next_select.sv
// Next-PC selection for the feedback thread: hold, then jump, then increment.
module pc_next_select
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 10
) (
  input  logic [PC_WIDTH-1:0] fb_pc,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] destination,
  input  logic                hold,
  output logic [PC_WIDTH-1:0] next_pc_c
);

  next_sel_e sel;

  // Priority decode; an annulled branch must re-execute, so hold beats jump
  always_comb begin
    sel = NEXT_INC;
    if (hold) begin
      sel = NEXT_HOLD;
    end else if (jump) begin
      sel = NEXT_JUMP;
    end
  end

  // Next-PC mux; the increment wraps naturally at PC_WIDTH bits
  always_comb begin
    next_pc_c = fb_pc + PC_WIDTH'(1);
    unique case (sel)
      NEXT_HOLD: next_pc_c = fb_pc;
      NEXT_JUMP: next_pc_c = destination;
      default:   next_pc_c = fb_pc + PC_WIDTH'(1);
    endcase
  end

endmodule

// File: rtl/pc_thread_sequencer.sv
// Round-robin per-thread PC issue stage with branch feedback write-back.
// Define PC_SEQUENCER_LOADER_EN to add the pc_wren/pc_wr_thread/pc_wr_data loader.
module pc_thread_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH           = 10,
  parameter int unsigned THREAD_COUNT       = 8,
  parameter int unsigned THREAD_COUNT_WIDTH = 3,
  parameter int unsigned START_PC           = 0,
  parameter int unsigned BRANCH_LATENCY     = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          jump,
  input  logic [PC_WIDTH-1:0]           destination,
  input  logic                          hold,
`ifdef PC_SEQUENCER_LOADER_EN
  input  logic                          pc_wren,
  input  logic [THREAD_COUNT_WIDTH-1:0] pc_wr_thread,
  input  logic [PC_WIDTH-1:0]           pc_wr_data,
`endif
  output logic [PC_WIDTH-1:0]           pc_out,
  output logic [THREAD_COUNT_WIDTH-1:0] thread_out,
  output logic                          pc_valid
);

  localparam int unsigned DLY = BRANCH_LATENCY - 1;

  typedef struct packed {
    logic                          valid;
    logic [THREAD_COUNT_WIDTH-1:0] thread;
    logic [PC_WIDTH-1:0]           pc;
  } fb_t;

  // Reject illegal configurations at elaboration
  if (THREAD_COUNT < 2) begin : g_bad_count
    $error("THREAD_COUNT must be at least 2");
  end
  if ((1 << THREAD_COUNT_WIDTH) < THREAD_COUNT) begin : g_bad_width
    $error("THREAD_COUNT_WIDTH too small for THREAD_COUNT");
  end
  if (BRANCH_LATENCY < 1 || BRANCH_LATENCY > THREAD_COUNT - 1) begin : g_bad_latency
    $error("BRANCH_LATENCY must be in 1..THREAD_COUNT-1");
  end

  logic [THREAD_COUNT_WIDTH-1:0] cnt;
  logic [PC_WIDTH-1:0]           pc_mem [THREAD_COUNT];
  logic [PC_WIDTH-1:0]           next_pc;
  logic [PC_WIDTH-1:0]           issue_pc;
  fb_t                           issue_rec;
  fb_t                           fb;

  assign issue_rec = '{valid: pc_valid, thread: thread_out, pc: pc_out};

  // Delay issued records so they line up with the branch result
  if (DLY == 0) begin : g_no_dly
    assign fb = issue_rec;
  end else begin : g_dly
    fb_t stage [DLY];

    // Shift register; reset drops every in-flight record
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int unsigned i = 0; i < DLY; i++) begin
          stage[i] <= '0;
        end
      end else begin
        stage[0] <= issue_rec;
        for (int unsigned i = 1; i < DLY; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign fb = stage[DLY-1];
  end

  pc_next_select #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_select (
    .fb_pc       (fb.pc),
    .jump        (jump),
    .destination (destination),
    .hold        (hold),
    .next_pc_c   (next_pc)
  );

  // Issue PC: loader write, then feedback bypass, then stored PC
  always_comb begin
    issue_pc = pc_mem[cnt];
    if (fb.valid && fb.thread == cnt) begin
      issue_pc = next_pc;
    end
`ifdef PC_SEQUENCER_LOADER_EN
    if (pc_wren && pc_wr_thread == cnt) begin
      issue_pc = pc_wr_data;
    end
`endif
  end

  // PC storage; a loader write lands after feedback and so takes precedence
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
        pc_mem[t] <= PC_WIDTH'(START_PC);
      end
    end else begin
      if (fb.valid) begin
        pc_mem[fb.thread] <= next_pc;
      end
`ifdef PC_SEQUENCER_LOADER_EN
      if (pc_wren && (int unsigned'(pc_wr_thread) < THREAD_COUNT)) begin
        pc_mem[pc_wr_thread] <= pc_wr_data;
      end
`endif
    end
  end

  // Issue register and round-robin thread counter
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      pc_out     <= PC_WIDTH'(START_PC);
      thread_out <= '0;
      pc_valid   <= 1'b0;
    end else begin
      pc_out     <= issue_pc;
      thread_out <= cnt;
      pc_valid   <= 1'b1;
      cnt        <= THREAD_COUNT_WIDTH'(thread_inc(32'(cnt), THREAD_COUNT));
    end
  end

endmodule

// File: tb/tb_pc_thread_sequencer.sv
// Scoreboard bench for pc_thread_sequencer; loader checks need PC_SEQUENCER_LOADER_EN.
module tb_pc_thread_sequencer;

  localparam int unsigned PW    = 10;
  localparam int unsigned T     = 8;
  localparam int unsigned TW    = 3;
  localparam int unsigned L     = 7;
  localparam int unsigned START = 0;
  localparam int unsigned PMOD  = 1 << PW;

  logic          clock = 1'b0;
  logic          reset;
  logic          jump;
  logic          hold;
  logic [PW-1:0] destination;
  logic          pc_wren;
  logic [TW-1:0] pc_wr_thread;
  logic [PW-1:0] pc_wr_data;
  logic [PW-1:0] pc_out;
  logic [TW-1:0] thread_out;
  logic          pc_valid;

  typedef struct {
    bit          valid;
    int unsigned thread;
    int unsigned pc;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        hist[$];
  int unsigned model_pc[T];
  int unsigned model_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  pc_thread_sequencer #(
    .PC_WIDTH           (PW),
    .THREAD_COUNT       (T),
    .THREAD_COUNT_WIDTH (TW),
    .START_PC           (START),
    .BRANCH_LATENCY     (L)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .jump         (jump),
    .destination  (destination),
    .hold         (hold),
`ifdef PC_SEQUENCER_LOADER_EN
    .pc_wren      (pc_wren),
    .pc_wr_thread (pc_wr_thread),
    .pc_wr_data   (pc_wr_data),
`endif
    .pc_out       (pc_out),
    .thread_out   (thread_out),
    .pc_valid     (pc_valid)
  );

  // The record whose branch result is due this cycle: issued L-1 cycles before the current output
  function automatic rec_t fb_now();
    rec_t r;
    r = '{valid: 1'b0, thread: 0, pc: 0};
    if (hist.size() >= L) r = hist[hist.size() - L];
    return r;
  endfunction

  // Drive one cycle, predict the issue it produces, then advance past the edge
  task automatic step(input bit rst, input bit j, input bit h, input int unsigned d,
                      input bit wr, input int unsigned wth, input int unsigned wdat);
    rec_t fb;
    rec_t e;
    reset        = rst;
    jump         = j;
    hold         = h;
    destination  = PW'(d);
    pc_wren      = wr;
    pc_wr_thread = TW'(wth);
    pc_wr_data   = PW'(wdat);
    if (rst) begin
      foreach (model_pc[t]) model_pc[t] = START;
      model_cnt = 0;
      foreach (hist[i]) hist[i].valid = 1'b0;
      e = '{valid: 1'b0, thread: 0, pc: START};
    end else begin
      fb = fb_now();
      if (fb.valid) begin
        if (h)      model_pc[fb.thread] = fb.pc;
        else if (j) model_pc[fb.thread] = d % PMOD;
        else        model_pc[fb.thread] = (fb.pc + 1) % PMOD;
      end
`ifdef PC_SEQUENCER_LOADER_EN
      if (wr && wth < T) model_pc[wth] = wdat % PMOD;
`endif
      e = '{valid: 1'b1, thread: model_cnt, pc: model_pc[model_cnt]};
      model_cnt = (model_cnt + 1) % T;
    end
    exp_q.push_back(e);
    hist.push_back(e);
    if (hist.size() > 64) hist.delete(0);
    @(posedge clock);
    #1;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  // Idle until the given thread's branch result is due; expiry is a failure
  task automatic wait_fb(input int unsigned th);
    rec_t f;
    for (int i = 0; i < 3 * T; i++) begin
      f = fb_now();
      if (f.valid && f.thread == th) return;
      quiet(1);
    end
    checks++;
    errors++;
    $display("FAIL wait_fb thread %0d: feedback slot never came due", th);
  endtask

  task automatic rand_run(input int n, input bit loader);
    bit          j;
    bit          h;
    bit          wr;
    for (int i = 0; i < n; i++) begin
      j  = ($urandom_range(0, 3) == 0);
      h  = ($urandom_range(0, 6) == 0);
      wr = loader && ($urandom_range(0, 5) == 0);
      step(1'b0, j, h, $urandom_range(0, PMOD - 1), wr, $urandom_range(0, T - 1),
           $urandom_range(0, PMOD - 1));
    end
  endtask

  // Monitor: compare every cycle's output against the oldest prediction
  initial begin
    rec_t e;
    @(posedge clock);
    forever begin
      @(negedge clock);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: output with no prediction (valid=%0d thread=%0d pc=%0h)",
                 pc_valid, thread_out, pc_out);
      end else begin
        e = exp_q.pop_front();
        if (pc_valid !== e.valid || thread_out !== TW'(e.thread) || pc_out !== PW'(e.pc)) begin
          errors++;
          $display("FAIL issue @%0t: got valid=%0d thread=%0d pc=%0h, want valid=%0d thread=%0d pc=%0h",
                   $time, pc_valid, thread_out, pc_out, e.valid, e.thread, e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then two full quiet rotations
    repeat (3) step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    quiet(16);

    // Thread 3 jumps
    wait_fb(3);
    step(1'b0, 1'b1, 1'b0, 'h155, 1'b0, 0, 0);
    quiet(9);

    // Thread 5: hold beats jump
    wait_fb(5);
    step(1'b0, 1'b1, 1'b1, 'h20, 1'b0, 0, 0);
    quiet(9);

    // Thread 2 to all-ones, then it wraps to zero
    wait_fb(2);
    step(1'b0, 1'b1, 1'b0, 'h3FF, 1'b0, 0, 0);
    quiet(20);

    // Thread 0 jumps; its very next issue must carry the target
    wait_fb(0);
    step(1'b0, 1'b1, 1'b0, 'h40, 1'b0, 0, 0);
    quiet(9);

    rand_run(300, 1'b0);

    // Reset with feedback in flight; branch inputs toggle after release and must be ignored
    rand_run(5, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 'h3A, 1'b0, 0, 0);
    rand_run(20, 1'b0);

`ifdef PC_SEQUENCER_LOADER_EN
    // Preload thread 2 with all-ones, then let it wrap
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 2, 'h3FF);
    quiet(20);
    // Loader beats a same-cycle feedback jump on thread 4
    wait_fb(4);
    step(1'b0, 1'b1, 1'b0, 'h11, 1'b1, 4, 'h77);
    quiet(9);
    // Loader targeting the thread being issued this cycle
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, model_cnt, 'h1AB);
    quiet(9);
    rand_run(200, 1'b1);
`endif

    rand_run(100, 1'b0);

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d predictions never observed", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
